// File: rtl/vga_raster_ctrl.sv
// VGA raster engine: mode timing, 1bpp framebuffer fetch with block scaling,
// and RGB332/sync output with every pin aligned to the same pipeline depth.
module vga_raster_ctrl #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   SCALE_SHIFT = 3,
    parameter int   ADDR_W      = 16,
    parameter int   RD_LATENCY  = 1
) (
    input  logic              clk_25m,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [7:0]        fg_color_i,
    input  logic [7:0]        bg_color_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rdata_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [2:0]        vga_r_o,
    output logic [2:0]        vga_g_o,
    output logic [1:0]        vga_b_o,
    output logic              vblank_o,
    output logic              frame_start_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int P       = RD_LATENCY + 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [VW-1:0]     BLK_MASK = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_VISIBLE >> SCALE_SHIFT);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
    } tag_t;

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic              h_last, v_last;
    logic              h_vis, v_vis;
    logic [VW-1:0]     v_next;
    logic [ADDR_W-1:0] pix_addr;
    tag_t              cur_tag;

    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    tag_t [P-1:0]      pipe_q, pipe_d;
    tag_t              out_tag;

    logic [7:0]        rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              vblank_q, vblank_d;
    logic              fs_q, fs_d;

    // Raster position decode for the current counter cycle.
    always_comb begin
        h_last   = (h_cnt_q == H_LAST);
        v_last   = (v_cnt_q == V_LAST);
        h_vis    = (h_cnt_q < H_VIS_C);
        v_vis    = (v_cnt_q < V_VIS_C);
        v_next   = v_cnt_q + VW'(1);
        pix_addr = row_base_q + ADDR_W'(h_cnt_q >> SCALE_SHIFT);

        cur_tag     = '0;
        cur_tag.vis = h_vis && v_vis;
        cur_tag.hs  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        cur_tag.vs  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        cur_tag.vb  = !v_vis;
        cur_tag.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        row_base_d = row_base_q;
        if (!enable_i) begin
            h_cnt_d    = '0;
            v_cnt_d    = '0;
            row_base_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            if (v_last) begin
                v_cnt_d    = '0;
                row_base_d = '0;
            end else begin
                v_cnt_d = v_next;
                // Next block row of bits starts after every 2^S lines.
                if (v_vis && ((v_next & BLK_MASK) == '0)) begin
                    row_base_d = row_base_q + ROW_STEP;
                end
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            row_base_q <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
        end
    end

    // Fetch stage: address is held outside visible area to avoid toggling.
    always_comb begin
        mem_rd_d   = enable_i && cur_tag.vis;
        mem_addr_d = mem_rd_d ? pix_addr : mem_addr_q;
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tags ride alongside the memory read so they meet mem_rdata.
    always_comb begin
        pipe_d = '0;
        if (enable_i) begin
            pipe_d = {pipe_q[P-2:0], cur_tag};
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_tag = pipe_q[P-1];

    always_comb begin
        rgb_d    = '0;
        hsync_d  = ~HSYNC_POL;
        vsync_d  = ~VSYNC_POL;
        vblank_d = 1'b0;
        fs_d     = 1'b0;
        if (enable_i) begin
            if (out_tag.vis) begin
                rgb_d = mem_rdata_i ? fg_color_i : bg_color_i;
            end
            hsync_d  = out_tag.hs ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = out_tag.vs ? VSYNC_POL : ~VSYNC_POL;
            vblank_d = out_tag.vb;
            fs_d     = out_tag.fs;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q    <= '0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
        end
    end

    assign mem_rd_o      = mem_rd_q;
    assign mem_addr_o    = mem_addr_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign vga_r_o       = rgb_q[7:5];
    assign vga_g_o       = rgb_q[4:2];
    assign vga_b_o       = rgb_q[1:0];
    assign vblank_o      = vblank_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_raster_ctrl.sv
// Directed bench for vga_raster_ctrl: a 640x480 instance with 2-cycle memory
// and a tiny 8x4 instance with positive syncs and unscaled bits.
module tb_vga_raster_ctrl;

    localparam int L_D = 4;
    localparam int L_T = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en_d = 1'b1;
    logic [7:0]  fg_d = 8'hE0;
    logic [7:0]  bg_d = 8'h03;
    logic        mem_rd_d;
    logic [15:0] mem_addr_d;
    logic        mem_rdata_d;
    logic        hsync_d, vsync_d, vblank_d, fs_d;
    logic [2:0]  r_d, g_d;
    logic [1:0]  b_d;

    logic        en_t = 1'b1;
    logic [7:0]  fg_t = 8'h5A;
    logic [7:0]  bg_t = 8'hA5;
    logic        mem_rd_t;
    logic [4:0]  mem_addr_t;
    logic        mem_rdata_t;
    logic        hsync_t, vsync_t, vblank_t, fs_t;
    logic [2:0]  r_t, g_t;
    logic [1:0]  b_t;

    vga_raster_ctrl #(
        .RD_LATENCY(2)
    ) dut_d (
        .clk_25m      (clk),
        .rst_n        (rst_n),
        .enable_i     (en_d),
        .fg_color_i   (fg_d),
        .bg_color_i   (bg_d),
        .mem_rd_o     (mem_rd_d),
        .mem_addr_o   (mem_addr_d),
        .mem_rdata_i  (mem_rdata_d),
        .hsync_o      (hsync_d),
        .vsync_o      (vsync_d),
        .vga_r_o      (r_d),
        .vga_g_o      (g_d),
        .vga_b_o      (b_d),
        .vblank_o     (vblank_d),
        .frame_start_o(fs_d)
    );

    vga_raster_ctrl #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .SCALE_SHIFT(0), .ADDR_W(5), .RD_LATENCY(1)
    ) dut_t (
        .clk_25m      (clk),
        .rst_n        (rst_n),
        .enable_i     (en_t),
        .fg_color_i   (fg_t),
        .bg_color_i   (bg_t),
        .mem_rd_o     (mem_rd_t),
        .mem_addr_o   (mem_addr_t),
        .mem_rdata_i  (mem_rdata_t),
        .hsync_o      (hsync_t),
        .vsync_o      (vsync_t),
        .vga_r_o      (r_t),
        .vga_g_o      (g_t),
        .vga_b_o      (b_t),
        .vblank_o     (vblank_t),
        .frame_start_o(fs_t)
    );

    // Synchronous video memories: only bit 0 set (big), bit = addr[0] (tiny).
    logic md1 = 1'b0, md2 = 1'b0, mt1 = 1'b0;
    always @(posedge clk) begin
        md1 <= (mem_addr_d == 16'd0);
        md2 <= md1;
        mt1 <= mem_addr_t[0];
    end
    assign mem_rdata_d = md2;
    assign mem_rdata_t = mt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic do_reset();
        rst_n = 1'b0;
        en_d  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_d !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd_d); end
        checks++; if (mem_addr_d !== 16'd0) begin failures++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr_d); end
        checks++; if ({r_d, g_d, b_d} !== 8'h00) begin failures++; $display("FAIL reset_rgb: got %h want 00", {r_d, g_d, b_d}); end
        checks++; if (hsync_d !== 1'b1) begin failures++; $display("FAIL reset_hsync: got %b want 1", hsync_d); end
        checks++; if (vsync_d !== 1'b1) begin failures++; $display("FAIL reset_vsync: got %b want 1", vsync_d); end
        checks++; if (vblank_d !== 1'b0) begin failures++; $display("FAIL reset_vblank: got %b want 0", vblank_d); end
        checks++; if (fs_d !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b want 0", fs_d); end
        checks++; if (hsync_t !== 1'b0) begin failures++; $display("FAIL reset_hsync_pos: got %b want 0", hsync_t); end
        checks++; if (vsync_t !== 1'b0) begin failures++; $display("FAIL reset_vsync_pos: got %b want 0", vsync_t); end
        checks++; if (mem_addr_t !== 5'd0) begin failures++; $display("FAIL reset_mem_addr_tiny: got %0d want 0", mem_addr_t); end
    endtask

    task automatic test_hsync();
        int first_low, last_low, lows, vs_lows, vb_highs;
        do_reset();
        first_low = -1;
        last_low  = -1;
        lows      = 0;
        vs_lows   = 0;
        vb_highs  = 0;
        for (int c = 0; c < 2400; c++) begin
            if (hsync_d === 1'b0) begin
                if (first_low < 0) first_low = cyc;
                last_low = cyc;
                lows++;
            end
            if (vsync_d !== 1'b1) vs_lows++;
            if (vblank_d !== 1'b0) vb_highs++;
            step();
        end
        checks++; if (first_low != 656 + L_D) begin failures++; $display("FAIL hsync_first_low: got %0d want %0d", first_low, 656 + L_D); end
        checks++; if (lows != 3 * 96) begin failures++; $display("FAIL hsync_low_count: got %0d want %0d", lows, 3 * 96); end
        checks++; if (last_low != 2 * 800 + 751 + L_D) begin failures++; $display("FAIL hsync_last_low: got %0d want %0d", last_low, 2 * 800 + 751 + L_D); end
        checks++; if (vs_lows != 0) begin failures++; $display("FAIL vsync_idle_lines: got %0d low cycles want 0", vs_lows); end
        checks++; if (vb_highs != 0) begin failures++; $display("FAIL vblank_visible_lines: got %0d high cycles want 0", vb_highs); end
    endtask

    // kind: 0 = RGB, 1 = mem_addr (with mem_rd high), 2 = frame_start
    task automatic test_pixels();
        int cy[15];
        int kd[15];
        int ex[15];
        cy = '{3, 4, 4, 5, 9, 11, 12, 643, 644, 5611, 5612, 6401, 6404, 6404, 6405};
        kd = '{0, 0, 2, 2, 1, 0,  0,  0,   0,   0,    0,    1,    0,    2,    0};
        ex = '{0, 'hE0, 1, 0, 1, 'hE0, 'h03, 'h03, 0, 'hE0, 'h03, 80, 'h03, 0, 'h03};
        fg_d = 8'hE0;
        bg_d = 8'h03;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_to(cy[i]);
            checks++;
            case (kd[i])
                0: if ({r_d, g_d, b_d} !== 8'(ex[i])) begin
                    failures++;
                    $display("FAIL pixel_rgb@%0d: got %h want %h", cyc, {r_d, g_d, b_d}, 8'(ex[i]));
                end
                1: if (mem_rd_d !== 1'b1 || mem_addr_d !== 16'(ex[i])) begin
                    failures++;
                    $display("FAIL fetch_addr@%0d: got rd=%b addr=%0d want rd=1 addr=%0d", cyc, mem_rd_d, mem_addr_d, ex[i]);
                end
                default: if (fs_d !== 1'(ex[i])) begin
                    failures++;
                    $display("FAIL frame_start@%0d: got %b want %0d", cyc, fs_d, ex[i]);
                end
            endcase
        end
    endtask

    task automatic test_tiny();
        int t, x, y, hs_hi, fs_n, max_addr;
        logic vis;
        logic [7:0] rgb;
        logic [11:0] exp_o, got_o;
        do_reset();
        hs_hi    = 0;
        fs_n     = 0;
        max_addr = -1;
        for (int c = 0; c <= 200; c++) begin
            vis = 1'b0;
            x   = 0;
            y   = 0;
            if (c >= 1) begin
                t   = c - 1;
                x   = t % 14;
                y   = (t / 14) % 7;
                vis = (x < 8) && (y < 4);
            end
            checks++;
            if (mem_rd_t !== vis) begin
                failures++;
                $display("FAIL tiny_mem_rd@%0d: got %b want %b", cyc, mem_rd_t, vis);
            end
            if (vis) begin
                checks++;
                if (mem_addr_t !== 5'(8 * y + x)) begin
                    failures++;
                    $display("FAIL tiny_mem_addr@%0d: got %0d want %0d", cyc, mem_addr_t, 8 * y + x);
                end
            end
            if (mem_rd_t === 1'b1 && int'(mem_addr_t) > max_addr) max_addr = int'(mem_addr_t);
            exp_o = '0;
            if (c >= L_T) begin
                t   = c - L_T;
                x   = t % 14;
                y   = (t / 14) % 7;
                rgb = ((x < 8) && (y < 4)) ? (((x % 2) == 1) ? fg_t : bg_t) : 8'h00;
                exp_o = {(x >= 10) && (x < 12), y == 5, y >= 4, (x == 0) && (y == 0), rgb};
            end
            got_o = {hsync_t, vsync_t, vblank_t, fs_t, r_t, g_t, b_t};
            checks++;
            if (got_o !== exp_o) begin
                failures++;
                $display("FAIL tiny_pins@%0d: got hs/vs/vb/fs/rgb=%h want %h", cyc, got_o, exp_o);
            end
            if (c >= L_T && c < L_T + 98 && hsync_t === 1'b1) hs_hi++;
            if (fs_t === 1'b1) fs_n++;
            step();
        end
        checks++; if (hs_hi != 14) begin failures++; $display("FAIL tiny_hsync_high_per_frame: got %0d want 14", hs_hi); end
        checks++; if (fs_n != 3) begin failures++; $display("FAIL tiny_frame_count: got %0d want 3", fs_n); end
        checks++; if (max_addr != 31) begin failures++; $display("FAIL tiny_last_addr: got %0d want 31", max_addr); end
    endtask

    task automatic test_enable();
        int k;
        fg_d = 8'hE0;
        bg_d = 8'h03;
        do_reset();
        run_to(805);
        checks++; if ({r_d, g_d, b_d} !== 8'hE0) begin failures++; $display("FAIL en_pre_rgb: got %h want e0", {r_d, g_d, b_d}); end
        en_d = 1'b0;
        step();
        checks++; if ({r_d, g_d, b_d} !== 8'h00) begin failures++; $display("FAIL en_off_rgb: got %h want 00", {r_d, g_d, b_d}); end
        checks++; if (mem_rd_d !== 1'b0) begin failures++; $display("FAIL en_off_mem_rd: got %b want 0", mem_rd_d); end
        checks++; if ({hsync_d, vsync_d, fs_d} !== 3'b110) begin failures++; $display("FAIL en_off_sync: got %b want 110", {hsync_d, vsync_d, fs_d}); end
        repeat (5) step();
        checks++; if ({r_d, g_d, b_d, mem_rd_d} !== 9'd0) begin failures++; $display("FAIL en_held_idle: got %h want 000", {r_d, g_d, b_d, mem_rd_d}); end
        k = cyc;
        en_d = 1'b1;
        step();
        checks++; if (mem_rd_d !== 1'b1 || mem_addr_d !== 16'd0) begin failures++; $display("FAIL en_restart_fetch: got rd=%b addr=%0d want rd=1 addr=0", mem_rd_d, mem_addr_d); end
        run_to(k + L_D - 1);
        checks++; if (fs_d !== 1'b0) begin failures++; $display("FAIL en_fs_early: got %b want 0", fs_d); end
        step();
        checks++; if (fs_d !== 1'b1 || {r_d, g_d, b_d} !== 8'hE0) begin failures++; $display("FAIL en_fs_on_time: got fs=%b rgb=%h want fs=1 rgb=e0", fs_d, {r_d, g_d, b_d}); end
        run_to(k + 700);
        checks++; if (hsync_d !== 1'b0) begin failures++; $display("FAIL en_hsync_active: got %b want 0", hsync_d); end
        en_d = 1'b0;
        step();
        checks++; if (hsync_d !== 1'b1) begin failures++; $display("FAIL en_hsync_drop: got %b want 1", hsync_d); end
        en_d = 1'b1;
    endtask

    task automatic test_async_reset();
        fg_d = 8'hE0;
        bg_d = 8'h03;
        do_reset();
        run_to(13);
        checks++; if ({r_d, g_d, b_d} !== 8'h03 || hsync_t !== 1'b1) begin failures++; $display("FAIL arst_pre: got rgb=%h hs_t=%b want 03 1", {r_d, g_d, b_d}, hsync_t); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({r_d, g_d, b_d} !== 8'h00) begin failures++; $display("FAIL arst_rgb: got %h want 00", {r_d, g_d, b_d}); end
        checks++; if (mem_rd_d !== 1'b0 || mem_addr_d !== 16'd0) begin failures++; $display("FAIL arst_fetch: got rd=%b addr=%0d want 0 0", mem_rd_d, mem_addr_d); end
        checks++; if (hsync_t !== 1'b0 || mem_addr_t !== 5'd0) begin failures++; $display("FAIL arst_tiny: got hs=%b addr=%0d want 0 0", hsync_t, mem_addr_t); end
        repeat (3) @(negedge clk);
        checks++; if ({hsync_d, vsync_d, vblank_d, fs_d} !== 4'b1100) begin failures++; $display("FAIL arst_held: got %b want 1100", {hsync_d, vsync_d, vblank_d, fs_d}); end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_pixels();
        test_tiny();
        test_enable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
